// File: rtl/rf_pkg.sv
// rf_pkg: shared sizes and types for the RISC240 register file
package rf_pkg;
  localparam int NREGS = 8;
  localparam int WIDTH = 16;
  localparam int SELW = 3;
  typedef logic [SELW-1:0] reg_sel_t;
  typedef logic [WIDTH-1:0] word_t;
  typedef enum logic [SELW-1:0] {R0, R1, R2, R3, R4, R5, R6, R7} reg_name_t;
endpackage

// File: rtl/mux2to1.sv
// mux2to1: generic two-input word selector
module mux2to1 #(
  parameter int WIDTH = 16
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);
  assign out = sel ? in1 : in0;
endmodule

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits with reserve handshake and write-completion bypass
module rf_scoreboard #(
  parameter int NREGS = rf_pkg::NREGS,
  parameter int SELW = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [SELW-1:0] selA,
  input  logic [SELW-1:0] selB,
  input  logic            wrEn,
  input  logic [SELW-1:0] wrSel,
  input  logic            rsvEn,
  input  logic [SELW-1:0] rsvSel,
  output logic            busyA,
  output logic            busyB,
  output logic            rsvOk,
  output logic            anyBusy
);
  logic [NREGS-1:0] busy;
  assign busyA = busy[selA] && !(wrEn && wrSel == selA);
  assign busyB = busy[selB] && !(wrEn && wrSel == selB);
  assign rsvOk = rsvEn && (!busy[rsvSel] || (wrEn && wrSel == rsvSel));
  assign anyBusy = |busy;
  // a write clears its register; an accepted reserve issued later in the block wins on the same index
  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (wrEn) busy[wrSel] <= 1'b0;
      if (rsvOk) busy[rsvSel] <= 1'b1;
    end
  end
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 8x16 register file with write-through bypass and busy scoreboard
module reg_file_sb #(
  parameter int WIDTH = rf_pkg::WIDTH,
  parameter int NREGS = rf_pkg::NREGS,
  parameter int SELW = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [SELW-1:0]  selA,
  input  logic [SELW-1:0]  selB,
  output logic [WIDTH-1:0] outA,
  output logic [WIDTH-1:0] outB,
  output logic             busyA,
  output logic             busyB,
  input  logic             wrEn,
  input  logic [SELW-1:0]  wrSel,
  input  logic [WIDTH-1:0] wrData,
  input  logic             rsvEn,
  input  logic [SELW-1:0]  rsvSel,
  output logic             rsvOk,
  output logic             anyBusy
);
  logic [WIDTH-1:0] regs [NREGS];
  // data array: reset clears everything and overrides a same-cycle write
  always_ff @(posedge clock) begin
    if (reset) regs <= '{default: '0};
    else if (wrEn) regs[wrSel] <= wrData;
  end
  mux2to1 #(.WIDTH(WIDTH)) u_mux_a (
    .sel(wrEn && wrSel == selA), .in0(regs[selA]), .in1(wrData), .out(outA)
  );
  mux2to1 #(.WIDTH(WIDTH)) u_mux_b (
    .sel(wrEn && wrSel == selB), .in0(regs[selB]), .in1(wrData), .out(outB)
  );
  rf_scoreboard #(.NREGS(NREGS), .SELW(SELW)) u_sb (
    .clock(clock), .reset(reset), .selA(selA), .selB(selB), .wrEn(wrEn), .wrSel(wrSel),
    .rsvEn(rsvEn), .rsvSel(rsvSel), .busyA(busyA), .busyB(busyB), .rsvOk(rsvOk), .anyBusy(anyBusy)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scenario tasks with an expected-value queue for reg_file_sb
module tb_reg_file_sb;
  import rf_pkg::*;
  logic clock = 0, reset = 0, wrEn = 0, rsvEn = 0;
  reg_sel_t selA = R0, selB = R0, wrSel = R0, rsvSel = R0;
  word_t wrData = '0, outA, outB, exp;
  logic busyA, busyB, rsvOk, anyBusy;
  word_t exp_q[$];
  int tests = 0, fails = 0;

  reg_file_sb dut (
    .clock(clock), .reset(reset), .selA(selA), .selB(selB), .outA(outA), .outB(outB),
    .busyA(busyA), .busyB(busyB), .wrEn(wrEn), .wrSel(wrSel), .wrData(wrData),
    .rsvEn(rsvEn), .rsvSel(rsvSel), .rsvOk(rsvOk), .anyBusy(anyBusy)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    wrEn = 0; rsvEn = 0; reset = 0;
  endtask

  task automatic test_reset;
    reset = 1; wrEn = 1; wrSel = R2; wrData = 16'h7777; rsvEn = 1; rsvSel = R2;
    tick;
    idle;
    for (int i = 0; i < NREGS; i++) begin
      selA = reg_sel_t'(i); selB = reg_sel_t'(NREGS - 1 - i);
      exp_q.push_back('0); exp_q.push_back('0); exp_q.push_back('0); exp_q.push_back('0); exp_q.push_back('0);
      #1;
      tests++; exp = exp_q.pop_front(); if (outA !== exp) begin fails++; $display("FAIL reset_outA[%0d] got %h want %h", i, outA, exp); end
      tests++; exp = exp_q.pop_front(); if (outB !== exp) begin fails++; $display("FAIL reset_outB[%0d] got %h want %h", i, outB, exp); end
      tests++; exp = exp_q.pop_front(); if (busyA !== exp[0]) begin fails++; $display("FAIL reset_busyA[%0d] got %b want %b", i, busyA, exp[0]); end
      tests++; exp = exp_q.pop_front(); if (busyB !== exp[0]) begin fails++; $display("FAIL reset_busyB[%0d] got %b want %b", i, busyB, exp[0]); end
      tests++; exp = exp_q.pop_front(); if (anyBusy !== exp[0]) begin fails++; $display("FAIL reset_anyBusy[%0d] got %b want %b", i, anyBusy, exp[0]); end
    end
  endtask

  task automatic test_write_read;
    selA = R3; wrEn = 1; wrSel = R3; wrData = 16'hBEEF;
    exp_q.push_back(16'hBEEF);
    #1;
    tests++; exp = exp_q.pop_front(); if (outA !== exp) begin fails++; $display("FAIL bypass_outA got %h want %h", outA, exp); end
    tick;
    idle;
    exp_q.push_back(16'hBEEF);
    #1;
    tests++; exp = exp_q.pop_front(); if (outA !== exp) begin fails++; $display("FAIL stored_outA got %h want %h", outA, exp); end
    for (int i = 0; i < NREGS; i++) begin
      if (i == 3) continue;
      selB = reg_sel_t'(i);
      exp_q.push_back('0);
      #1;
      tests++; exp = exp_q.pop_front(); if (outB !== exp) begin fails++; $display("FAIL other_reg[%0d] got %h want %h", i, outB, exp); end
    end
  endtask

  task automatic test_reserve;
    rsvEn = 1; rsvSel = R5; selA = R5;
    exp_q.push_back(16'd1); exp_q.push_back(16'd0);
    #1;
    tests++; exp = exp_q.pop_front(); if (rsvOk !== exp[0]) begin fails++; $display("FAIL rsv_ok_free got %b want %b", rsvOk, exp[0]); end
    tests++; exp = exp_q.pop_front(); if (busyA !== exp[0]) begin fails++; $display("FAIL rsv_busy_before_edge got %b want %b", busyA, exp[0]); end
    tick;
    rsvEn = 0;
    exp_q.push_back(16'd1); exp_q.push_back(16'd1);
    #1;
    tests++; exp = exp_q.pop_front(); if (busyA !== exp[0]) begin fails++; $display("FAIL rsv_busyA got %b want %b", busyA, exp[0]); end
    tests++; exp = exp_q.pop_front(); if (anyBusy !== exp[0]) begin fails++; $display("FAIL rsv_anyBusy got %b want %b", anyBusy, exp[0]); end
    rsvEn = 1;
    exp_q.push_back(16'd0);
    #1;
    tests++; exp = exp_q.pop_front(); if (rsvOk !== exp[0]) begin fails++; $display("FAIL rsv_ok_busy got %b want %b", rsvOk, exp[0]); end
    tick;
    rsvEn = 0;
    exp_q.push_back(16'd1);
    #1;
    tests++; exp = exp_q.pop_front(); if (busyA !== exp[0]) begin fails++; $display("FAIL rsv_still_busy got %b want %b", busyA, exp[0]); end
    wrEn = 1; wrSel = R5; wrData = 16'h1234;
    exp_q.push_back(16'd0); exp_q.push_back(16'h1234); exp_q.push_back(16'd1);
    #1;
    tests++; exp = exp_q.pop_front(); if (busyA !== exp[0]) begin fails++; $display("FAIL complete_busyA got %b want %b", busyA, exp[0]); end
    tests++; exp = exp_q.pop_front(); if (outA !== exp) begin fails++; $display("FAIL complete_outA got %h want %h", outA, exp); end
    tests++; exp = exp_q.pop_front(); if (anyBusy !== exp[0]) begin fails++; $display("FAIL complete_anyBusy_reg got %b want %b", anyBusy, exp[0]); end
    tick;
    idle;
    exp_q.push_back(16'd0);
    #1;
    tests++; exp = exp_q.pop_front(); if (anyBusy !== exp[0]) begin fails++; $display("FAIL complete_anyBusy got %b want %b", anyBusy, exp[0]); end
  endtask

  task automatic test_write_reserve_same;
    rsvEn = 1; rsvSel = R2;
    tick;
    idle;
    selA = R2; selB = R7;
    wrEn = 1; wrSel = R2; wrData = 16'h00FF; rsvEn = 1; rsvSel = R2;
    exp_q.push_back(16'd1);
    #1;
    tests++; exp = exp_q.pop_front(); if (rsvOk !== exp[0]) begin fails++; $display("FAIL wr_rsv_ok got %b want %b", rsvOk, exp[0]); end
    tick;
    idle;
    exp_q.push_back(16'h00FF); exp_q.push_back(16'd1); exp_q.push_back(16'd0);
    #1;
    tests++; exp = exp_q.pop_front(); if (outA !== exp) begin fails++; $display("FAIL wr_rsv_data got %h want %h", outA, exp); end
    tests++; exp = exp_q.pop_front(); if (busyA !== exp[0]) begin fails++; $display("FAIL wr_rsv_busy got %b want %b", busyA, exp[0]); end
    tests++; exp = exp_q.pop_front(); if (busyB !== exp[0]) begin fails++; $display("FAIL wr_rsv_other_busy got %b want %b", busyB, exp[0]); end
    wrEn = 1; wrSel = R2; wrData = 16'h00FF;
    tick;
    idle;
  endtask

  task automatic test_reset_mid;
    wrEn = 1; wrSel = R1; wrData = 16'hAAAA; rsvEn = 1; rsvSel = R6;
    tick;
    idle;
    selA = R1; selB = R6;
    exp_q.push_back(16'hAAAA); exp_q.push_back(16'd1);
    #1;
    tests++; exp = exp_q.pop_front(); if (outA !== exp) begin fails++; $display("FAIL mid_pre_outA got %h want %h", outA, exp); end
    tests++; exp = exp_q.pop_front(); if (busyB !== exp[0]) begin fails++; $display("FAIL mid_pre_busyB got %b want %b", busyB, exp[0]); end
    reset = 1; wrEn = 1; wrSel = R1; wrData = 16'h5555;
    tick;
    idle;
    exp_q.push_back(16'd0); exp_q.push_back(16'd0); exp_q.push_back(16'd0);
    #1;
    tests++; exp = exp_q.pop_front(); if (outA !== exp) begin fails++; $display("FAIL mid_outA got %h want %h", outA, exp); end
    tests++; exp = exp_q.pop_front(); if (busyB !== exp[0]) begin fails++; $display("FAIL mid_busyB got %b want %b", busyB, exp[0]); end
    tests++; exp = exp_q.pop_front(); if (anyBusy !== exp[0]) begin fails++; $display("FAIL mid_anyBusy got %b want %b", anyBusy, exp[0]); end
  endtask

  task automatic test_alias;
    selA = R4; selB = R4; wrEn = 1; wrSel = R4; wrData = 16'h0F0F;
    exp_q.push_back(16'h0F0F); exp_q.push_back(16'h0F0F);
    #1;
    tests++; exp = exp_q.pop_front(); if (outA !== exp) begin fails++; $display("FAIL alias_byp_outA got %h want %h", outA, exp); end
    tests++; exp = exp_q.pop_front(); if (outB !== exp) begin fails++; $display("FAIL alias_byp_outB got %h want %h", outB, exp); end
    tick;
    idle;
    exp_q.push_back(16'h0F0F); exp_q.push_back(16'h0F0F);
    #1;
    tests++; exp = exp_q.pop_front(); if (outA !== exp) begin fails++; $display("FAIL alias_reg_outA got %h want %h", outA, exp); end
    tests++; exp = exp_q.pop_front(); if (outB !== exp) begin fails++; $display("FAIL alias_reg_outB got %h want %h", outB, exp); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_reserve;
    test_write_reserve_same;
    test_reset_mid;
    test_alias;
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL queue_drain got %0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
